// File: rtl/lca_rf_pkg.sv
// lca_rf_pkg: shared register-file constants, types and the operand bypass helper.
//   WIDTH  data width of each register
//   NREG   number of registers
//   AW     register address width
package lca_rf_pkg;
    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int AW    = 3;
    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [WIDTH-1:0] word_t;
    // A same-cycle writeback to src overrides the register file, which only updates at the end of the cycle.
    function automatic word_t pick(input logic [NREG*WIDTH-1:0] rf, input reg_addr_t src,
                                   input logic wb_write, input reg_addr_t wb_addr, input word_t wb_data);
        return (!wb_write && wb_addr == src) ? wb_data : rf[int'(src)*WIDTH +: WIDTH];
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: in-flight destination tracking and RAW/WAW hazard lookup with writeback bypass.
//   clk, reset       clock, asynchronous active-low reset
//   wb_write         active-low writeback strobe; wb_addr is the register retiring
//   set_en, set_addr mark set_addr in flight (wins over a same-cycle clear)
//   ra, rb, rd       addresses to check; rd only counts when rd_chk is high
//   hazard           some checked register is busy and not being written back now
//   busy             scoreboard vector
module rf_scoreboard
    import lca_rf_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_write,
    input  reg_addr_t       wb_addr,
    input  logic            set_en,
    input  reg_addr_t       set_addr,
    input  reg_addr_t       ra,
    input  reg_addr_t       rb,
    input  reg_addr_t       rd,
    input  logic            rd_chk,
    output logic            hazard,
    output logic [NREG-1:0] busy
);
    logic [NREG-1:0] busy_q, busy_d, wb_mask, live;

    assign wb_mask = wb_write ? '0 : NREG'(1) << wb_addr;
    // A register being written back this cycle is already available through the bypass.
    assign live    = busy_q & ~wb_mask;
    assign hazard  = live[ra] || live[rb] || (rd_chk && live[rd]);
    assign busy    = busy_q;

    always_comb begin
        busy_d = busy_q & ~wb_mask;
        if (set_en) busy_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads two source operands with writeback bypass, stalls on hazards, one-entry output slot.
//   clk, reset                   clock, asynchronous active-low reset
//   rf_data                      flattened register file contents
//   in_valid/in_ready            decode handshake; in_ra, in_rb, in_rd, in_wr_en instruction fields
//   wb_write, wb_addr, wb_data   writeback port (wb_write active-low)
//   out_valid/out_ready          execute handshake; out_a, out_b, out_rd, out_wr_en payload
//   busy                         scoreboard of in-flight destinations
module operand_fetch
    import lca_rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREG*WIDTH-1:0] rf_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_ra,
    input  logic [AW-1:0]         in_rb,
    input  logic [AW-1:0]         in_rd,
    input  logic                  in_wr_en,
    input  logic                  wb_write,
    input  logic [AW-1:0]         wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b,
    output logic [AW-1:0]         out_rd,
    output logic                  out_wr_en,
    output logic [NREG-1:0]       busy
);
    typedef enum logic {EMPTY, FULL} slot_e;

    slot_e     state_q, state_d;
    word_t     a_q, a_d, b_q, b_d;
    reg_addr_t rd_q, rd_d;
    logic      wr_en_q, wr_en_d, hazard, accept;

    rf_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .wb_write (wb_write),
        .wb_addr  (wb_addr),
        .set_en   (accept && in_wr_en),
        .set_addr (in_rd),
        .ra       (in_ra),
        .rb       (in_rb),
        .rd       (in_rd),
        .rd_chk   (in_wr_en),
        .hazard   (hazard),
        .busy     (busy)
    );

    assign out_valid = (state_q == FULL);
    assign in_ready  = !hazard && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_rd    = rd_q;
    assign out_wr_en = wr_en_q;

    always_comb begin
        state_d = accept ? FULL : (out_valid && out_ready) ? EMPTY : state_q;
        a_d     = accept ? pick(rf_data, in_ra, wb_write, wb_addr, wb_data) : a_q;
        b_d     = accept ? pick(rf_data, in_rb, wb_write, wb_addr, wb_data) : b_q;
        rd_d    = accept ? in_rd : rd_q;
        wr_en_d = accept ? in_wr_en : wr_en_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            wr_en_q <= wr_en_d;
        end
    end
endmodule
